// File: rtl/seg7_pkg.sv
// seg7_pkg: definitions shared by the seven-segment scan controller.
//   - scan_state_t : BLANK / DRIVE slot phases
//   - SEG_OFF, AN_OFF : all-off levels for the active-low segment and anode buses
//   - SEG_PAT : hex digit patterns, active-low, bit order gfedcba
//   - frame_snap_t : the input fields captured once per frame
//   - lz_suppressed : leading-zero test for one digit position
package seg7_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Entry n is the pattern for hex digit n. Written from F down to 0
    // because the first element of a packed concatenation is the MSB.
    localparam logic [15:0][6:0] SEG_PAT = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp_in;
        logic [3:0]  digit_en;
        logic        lz_blank;
    } frame_snap_t;

    // A digit is a leading zero when it and every higher nibble are zero.
    // Digit 0 always shows, so a value of zero still displays "0".
    function automatic logic lz_suppressed(input logic [15:0] v, input logic [1:0] idx);
        logic r;
        case (idx)
            2'd1:    r = (v[15:4] == 12'h000);
            2'd2:    r = (v[15:8] == 8'h00);
            2'd3:    r = (v[15:12] == 4'h0);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational hex nibble to seven-segment pattern lookup.
//   nibble  : hex digit 0-F
//   pattern : active-low segments, pattern[0]=a ... pattern[6]=g
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    assign pattern = SEG_PAT[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for a 4-digit,
// common-anode seven-segment display. Each digit owns a slot of SCAN_DIV
// clk cycles: BLANK_CYCLES with every anode off (ghosting guard), then the
// remainder driving that digit. All timing is counted in the clk domain.
//   clk, reset : clock and synchronous active-high reset
//   value      : four hex nibbles, [3:0] is digit 0 (rightmost)
//   dp_in      : decimal point request per digit, 1 = lit
//   digit_en   : per-digit enable, 0 keeps that anode off
//   lz_blank   : leading-zero suppression enable
//   an         : anodes, active-low
//   seg        : segments, active-low, seg[0]=a ... seg[6]=g
//   dp         : decimal point, active-low
//   scan_tick  : one-cycle pulse on the last cycle of each slot
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV     = 65536,
    parameter int BLANK_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    input  logic        lz_blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        scan_tick
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    scan_state_t state, state_next;
    logic [1:0]    digit_idx, idx_next;
    logic [CW-1:0] slot_cnt, cnt_next;
    frame_snap_t   snapshot, snap_eff;

    logic          capture;
    logic [3:0]    nibble;
    logic [6:0]    pattern;
    logic          suppress;
    logic          anode_on;
    logic [3:0]    an_next;
    logic [6:0]    seg_next;
    logic          dp_next;
    logic          tick_next;

    // Outputs are computed from the next state so that the registered
    // outputs line up cycle-for-cycle with state/slot_cnt.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= BLANK;
            digit_idx <= 2'd0;
            slot_cnt  <= '0;
            snapshot  <= '0;
            an        <= AN_OFF;
            seg       <= SEG_OFF;
            dp        <= 1'b1;
            scan_tick <= 1'b0;
        end else begin
            state     <= state_next;
            digit_idx <= idx_next;
            slot_cnt  <= cnt_next;
            snapshot  <= snap_eff;
            an        <= an_next;
            seg       <= seg_next;
            dp        <= dp_next;
            scan_tick <= tick_next;
        end
    end

    // Frame start: first cycle of digit 0. The live inputs are used in that
    // cycle as well as latched, so digit 0 decodes the new frame even when
    // BLANK_CYCLES is 1.
    assign capture  = (state == BLANK) && (digit_idx == 2'd0) && (slot_cnt == '0);
    assign snap_eff = capture ? '{value: value, dp_in: dp_in, digit_en: digit_en,
                                  lz_blank: lz_blank}
                              : snapshot;

    always_comb begin
        cnt_next  = slot_cnt + 1'b1;
        idx_next  = digit_idx;
        tick_next = 1'b0;
        if (slot_cnt == SLOT_LAST) begin
            cnt_next = '0;
            idx_next = digit_idx + 2'd1;
        end
        if (cnt_next == SLOT_LAST) begin
            tick_next = 1'b1;
        end
        state_next = (cnt_next < BLANK_END) ? BLANK : DRIVE;
    end

    assign nibble = snap_eff.value[{idx_next, 2'b00} +: 4];

    seg7_hex_decode u_decode (
        .nibble  (nibble),
        .pattern (pattern)
    );

    always_comb begin
        an_next  = AN_OFF;
        seg_next = SEG_OFF;
        dp_next  = 1'b1;
        suppress = snap_eff.lz_blank && lz_suppressed(snap_eff.value, idx_next);
        // A suppressed digit still lights when its decimal point is wanted.
        anode_on = snap_eff.digit_en[idx_next] && (!suppress || snap_eff.dp_in[idx_next]);
        if (state_next == DRIVE && anode_on) begin
            an_next  = ~(4'b0001 << idx_next);
            seg_next = suppress ? SEG_OFF : pattern;
            dp_next  = ~snap_eff.dp_in[idx_next];
        end
    end

endmodule
